filter_sample_ctrl: RTL and testbench

- Sequencing stage directly upstream and downstream of the combinational difference-equation filter.
- Paces the audio sample rate from the system clock and handshakes one ADC sample per sample period.
- Holds the input history x[n], x[n-1] and the feedback y[n-1] that the filter consumes.
- After the filter output settles, registers it as both the next feedback value and the outgoing audio sample.

---
 rtl/filter_sample_ctrl.sv | 124 ++++++++++++
 tb/tb_filter_sample_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/filter_sample_ctrl.sv
// Sample-rate sequencer around a combinational difference-equation filter:
// paces ADC handshakes, holds x[n]/x[n-1]/y[n-1], and commits the settled filter output.
module filter_sample_ctrl #(
  parameter int N             = 10,
  parameter int CLK_HZ        = 50000000,
  parameter int FS_HZ         = 48000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   adc_data,
  input  logic           adc_valid,
  output logic           adc_ready,
  input  logic           bypass,
  output logic [2*N-1:0] x_hist,
  output logic [N-1:0]   y_fb,
  output logic [16:0]    fs_out,
  input  logic [N-1:0]   filt_out,
  output logic [N-1:0]   sample_out,
  output logic           sample_valid,
  output logic           overrun
);

  localparam int DIV   = CLK_HZ / FS_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [N-1:0]     MIDSCALE    = {1'b1, {(N-1){1'b0}}};
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ADC = 2'd1;
  localparam logic [1:0] SETTLE   = 2'd2;
  localparam logic [1:0] COMMIT   = 2'd3;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       state;
  logic [SET_W-1:0] settle_cnt;
  logic [N-1:0]     x_cur;
  logic [N-1:0]     x_prev;
  logic             handshake;

  assign tick      = (div_cnt == DIV_LAST);
  assign handshake = adc_valid && adc_ready;
  assign x_hist    = {x_prev, x_cur};
  assign fs_out    = 17'(FS_HZ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      x_cur        <= MIDSCALE;
      x_prev       <= MIDSCALE;
      y_fb         <= MIDSCALE;
      sample_out   <= MIDSCALE;
      adc_ready    <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            adc_ready <= 1'b1;
            state     <= WAIT_ADC;
          end
        end
        WAIT_ADC: begin
          // A handshake coinciding with tick wins; only a missed period repeats x[n].
          if (handshake) begin
            x_prev     <= x_cur;
            x_cur      <= adc_data;
            adc_ready  <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else if (tick) begin
            x_prev     <= x_cur;
            adc_ready  <= 1'b0;
            overrun    <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (tick) begin
            overrun <= 1'b1;
          end
          if (settle_cnt == SETTLE_ONE) begin
            state <= COMMIT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        COMMIT: begin
          if (tick) begin
            overrun <= 1'b1;
          end
          y_fb         <= filt_out;
          sample_out   <= bypass ? x_cur : filt_out;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state     <= IDLE;
          adc_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_sample_ctrl.sv
// Directed-vector bench for filter_sample_ctrl with a 10-clock sample period.
module tb_filter_sample_ctrl;

  localparam int N = 10;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   adc_data;
  logic           adc_valid;
  logic           adc_ready;
  logic           bypass;
  logic [2*N-1:0] x_hist;
  logic [N-1:0]   y_fb;
  logic [16:0]    fs_out;
  logic [N-1:0]   filt_out;
  logic [N-1:0]   sample_out;
  logic           sample_valid;
  logic           overrun;

  int vectors;
  int miscompares;
  int t;
  int valid_count;
  int vc_saved;

  filter_sample_ctrl #(
    .N(N), .CLK_HZ(1000), .FS_HZ(100), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_ready(adc_ready), .bypass(bypass), .x_hist(x_hist), .y_fb(y_fb),
    .fs_out(fs_out), .filt_out(filt_out), .sample_out(sample_out),
    .sample_valid(sample_valid), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample_valid === 1'b1) valid_count <= valid_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("vec %0d t=%0d %s obs=%0d exp=%0d", vectors, t, tag, obs, exp);
  endtask

  // advance to 1ns after rising edge number e counted from the last reset release
  task automatic goto(input int e);
    while (t < e) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  initial begin
    int pdata [3];
    int pfilt [3];
    pdata = '{100, 200, 300};
    pfilt = '{111, 222, 333};
    vectors = 0; miscompares = 0; t = 0; valid_count = 0; vc_saved = 0;
    reset_n = 1'b0; adc_valid = 1'b0; adc_data = '0; bypass = 1'b0; filt_out = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_out", 32'(sample_out), 512);
    chk("rst_y_fb", 32'(y_fb), 512);
    chk("rst_x_hist", 32'(x_hist), {10'd512, 10'd512});
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_ready", 32'(adc_ready), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("fs_out", 32'(fs_out), 100);

    reset_n = 1'b1; t = 0;
    adc_valid = 1'b1; adc_data = 10'd700; filt_out = 10'd600;
    goto(9);  chk("ready_before_tick", 32'(adc_ready), 0);
    goto(10); chk("ready_cycle11", 32'(adc_ready), 1);
    goto(11); chk("x_hist_700", 32'(x_hist), {10'd512, 10'd700});
              chk("ready_drop", 32'(adc_ready), 0);
    goto(13); chk("valid_commit", 32'(sample_valid), 0);
    goto(14); chk("valid_pulse", 32'(sample_valid), 1);
              chk("sample_600", 32'(sample_out), 600);
              chk("y_fb_600", 32'(y_fb), 600);
              chk("overrun_0", 32'(overrun), 0);
    goto(15); chk("valid_end", 32'(sample_valid), 0);
              chk("valid_count1", 32'(valid_count), 1);

    for (int p = 0; p < 3; p++) begin
      adc_data = 10'(pdata[p]);
      filt_out = 10'(pfilt[p]);
      goto(10 * (p + 2) + 1);
      chk("shift_x_hist", 32'(x_hist), {10'((p == 0) ? 700 : pdata[p-1]), 10'(pdata[p])});
      goto(10 * (p + 2) + 4);
      chk("shift_valid", 32'(sample_valid), 1);
      chk("shift_sample", 32'(sample_out), 32'(pfilt[p]));
    end
    goto(45); chk("valid_count4", 32'(valid_count), 4);

    adc_valid = 1'b0; filt_out = 10'd333;
    goto(50); chk("miss_ready", 32'(adc_ready), 1);
    goto(60); chk("miss_x_hist", 32'(x_hist), {10'd300, 10'd300});
              chk("miss_overrun", 32'(overrun), 1);
              chk("miss_ready_drop", 32'(adc_ready), 0);
    goto(63); chk("miss_valid", 32'(sample_valid), 1);
              chk("miss_sample", 32'(sample_out), 333);

    adc_valid = 1'b1; adc_data = 10'd800; filt_out = 10'd400; bypass = 1'b1;
    goto(71); chk("byp_x_hist", 32'(x_hist), {10'd300, 10'd800});
    goto(74); chk("byp_valid", 32'(sample_valid), 1);
              chk("byp_sample", 32'(sample_out), 800);
              chk("byp_y_fb", 32'(y_fb), 400);
              chk("overrun_sticky", 32'(overrun), 1);

    bypass = 1'b0; adc_data = 10'd50; filt_out = 10'd77;
    goto(81); chk("pre_rst_x_hist", 32'(x_hist), {10'd800, 10'd50});
    goto(82);
    vc_saved = valid_count;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sample", 32'(sample_out), 512);
    chk("mid_rst_y_fb", 32'(y_fb), 512);
    chk("mid_rst_x_hist", 32'(x_hist), {10'd512, 10'd512});
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_ready", 32'(adc_ready), 0);
    chk("mid_rst_valid", 32'(sample_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1; t = 0;
    adc_data = 10'd100; filt_out = 10'd600;
    goto(9);  chk("rerun_ready_0", 32'(adc_ready), 0);
    goto(10); chk("rerun_ready_1", 32'(adc_ready), 1);
              chk("no_pulse_in_reset", 32'(valid_count), 32'(vc_saved));
    goto(11); chk("rerun_x_hist", 32'(x_hist), {10'd512, 10'd100});
    goto(14); chk("rerun_valid", 32'(sample_valid), 1);
              chk("rerun_sample", 32'(sample_out), 600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
